// File: rtl/tdm_demux2_if.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux2_if
//  Brief    : Serial TDM input and demultiplexed word outputs for tdm_demux2.
//  Revision : 1.0  initial release
// ============================================================================
interface tdm_demux2_if #(
    parameter int WIDTH = 4
);
    logic             din;
    logic             sync;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic             v0;
    logic             v1;
    logic             sel;
    logic             locked;
    logic             err;

    modport master (
        output din, sync,
        input  y0, y1, v0, v1, sel, locked, err
    );

    modport slave (
        input  din, sync,
        output y0, y1, v0, v1, sel, locked, err
    );
endinterface
`default_nettype wire

// File: rtl/tdm_demux2.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux2
//  Brief    : Rebuilds two WIDTH-bit channel words from a framed serial TDM stream.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux2 #(
    parameter int WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    tdm_demux2_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SLOT0 = 2'd1,
        SLOT1 = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [WIDTH-1:0] w_word;
    logic             w_frame_start;
    logic             w_ld0, w_ld1, w_err;

    logic [WIDTH-1:0] r_y0, r_y1;
    logic             r_v0, r_v1, r_err, r_sel, r_locked;

    assign w_word        = {r_shreg[WIDTH-2:0], bus.din};
    assign w_frame_start = (r_state == SLOT0) && (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_ld0       = 1'b0;
        w_ld1       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            HUNT: begin
                if (bus.sync) begin
                    w_state_nxt = SLOT0;
                    w_cnt_nxt   = C_ONE;
                    w_shreg_nxt = {{(WIDTH-1){1'b0}}, bus.din};
                end
            end
            SLOT0, SLOT1: begin
                // A misplaced SYNC resynchronises and takes priority over word completion
                if (bus.sync && !w_frame_start) begin
                    w_err       = 1'b1;
                    w_state_nxt = SLOT0;
                    w_cnt_nxt   = C_ONE;
                    w_shreg_nxt = {{(WIDTH-1){1'b0}}, bus.din};
                end else if (w_frame_start && !bus.sync) begin
                    w_err       = 1'b1;
                    w_state_nxt = HUNT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_shreg_nxt = w_word;
                    if (r_cnt == C_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_state == SLOT0) begin
                            w_ld0       = 1'b1;
                            w_state_nxt = SLOT1;
                        end else begin
                            w_ld1       = 1'b1;
                            w_state_nxt = SLOT0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + C_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= HUNT;
            r_cnt    <= '0;
            r_shreg  <= '0;
            r_y0     <= '0;
            r_y1     <= '0;
            r_v0     <= 1'b0;
            r_v1     <= 1'b0;
            r_err    <= 1'b0;
            r_sel    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shreg  <= w_shreg_nxt;
            if (w_ld0) r_y0 <= w_word;
            if (w_ld1) r_y1 <= w_word;
            r_v0     <= w_ld0;
            r_v1     <= w_ld1;
            r_err    <= w_err;
            r_sel    <= (w_state_nxt == SLOT1);
            r_locked <= (w_state_nxt != HUNT);
        end
    end

    assign bus.y0     = r_y0;
    assign bus.y1     = r_y1;
    assign bus.v0     = r_v0;
    assign bus.v1     = r_v1;
    assign bus.err    = r_err;
    assign bus.sel    = r_sel;
    assign bus.locked = r_locked;
endmodule
`default_nettype wire
